// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - core-to-display bundle for seg7_scan_driver
//
// Purpose: groups the staging inputs and the display pins of the scan driver.
// Signals:
//   load        single-cycle request to stage new display contents
//   data_in     nibble i (bits 4i+3:4i) is the hex value for digit i
//   dp_in       decimal point per digit, 1 = lit
//   en_in       digit enable per digit, 1 = shown
//   seg_an      anode select, active-low
//   seg_out     {dp,g,f,e,d,c,b,a}, active-low
//   frame_start one-cycle pulse when slot 0 of a new frame begins
// master = core side (drives staging inputs), slave = scan driver.
interface seg7_scan_driver_if;
  logic        load;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic [7:0]  en_in;
  logic [7:0]  seg_an;
  logic [7:0]  seg_out;
  logic        frame_start;

  modport master (
    output load, data_in, dp_in, en_in,
    input  seg_an, seg_out, frame_start
  );

  modport slave (
    input  load, data_in, dp_in, en_in,
    output seg_an, seg_out, frame_start
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 8-digit seven-segment scan driver
//
// Purpose: time-multiplexes up to 8 digits, blanks the start of every digit
// slot to suppress ghosting, and commits staged data only at frame boundaries.
// Ports:
//   clk  system clock, all logic on posedge
//   rst  synchronous reset, active-high
//   bus  seg7_scan_driver_if.slave (load/data_in/dp_in/en_in in,
//        seg_an/seg_out/frame_start out, all outputs registered)
module seg7_scan_driver #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_driver_if.slave   bus
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;

  logic          pending_valid;
  logic [31:0]   stg_data;
  logic [7:0]    stg_dp;
  logic [7:0]    stg_en;

  logic [31:0]   disp_data;
  logic [7:0]    disp_dp;
  logic [7:0]    disp_en;

  logic [7:0]    an_q;
  logic [7:0]    seg_q;
  logic          fs_q;

  logic          slot_end;
  logic          frame_end;
  logic [3:0]    nib;
  logic [7:0]    an_d;
  logic [7:0]    seg_d;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0:    decode = 7'h40;
      4'h1:    decode = 7'h79;
      4'h2:    decode = 7'h24;
      4'h3:    decode = 7'h30;
      4'h4:    decode = 7'h19;
      4'h5:    decode = 7'h12;
      4'h6:    decode = 7'h02;
      4'h7:    decode = 7'h78;
      4'h8:    decode = 7'h00;
      4'h9:    decode = 7'h10;
      4'hA:    decode = 7'h08;
      4'hB:    decode = 7'h03;
      4'hC:    decode = 7'h46;
      4'hD:    decode = 7'h21;
      4'hE:    decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  assign slot_end  = (cnt == CW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (idx == 3'(DIGITS - 1));

  // Slot counter and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == 3'(DIGITS - 1)) ? 3'd0 : idx + 3'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Staging and frame-boundary commit. A load on the boundary cycle bypasses
  // the staging registers so the newest values win and nothing stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_valid <= 1'b0;
      stg_data      <= '0;
      stg_dp        <= '0;
      stg_en        <= '0;
      disp_data     <= '0;
      disp_dp       <= '0;
      disp_en       <= '0;
    end else begin
      if (bus.load) begin
        stg_data <= bus.data_in;
        stg_dp   <= bus.dp_in;
        stg_en   <= bus.en_in;
      end
      if (frame_end && bus.load) begin
        disp_data     <= bus.data_in;
        disp_dp       <= bus.dp_in;
        disp_en       <= bus.en_in;
        pending_valid <= 1'b0;
      end else if (frame_end && pending_valid) begin
        disp_data     <= stg_data;
        disp_dp       <= stg_dp;
        disp_en       <= stg_en;
        pending_valid <= 1'b0;
      end else if (bus.load) begin
        pending_valid <= 1'b1;
      end
    end
  end

  // Next pin values from the current slot; registering them gives the
  // one-cycle lag behind cnt/idx.
  always_comb begin
    an_d  = 8'hFF;
    seg_d = 8'hFF;
    nib   = disp_data[{idx, 2'b00} +: 4];
    if (cnt >= CW'(BLANK_CYCLES) && disp_en[idx]) begin
      an_d  = ~(8'd1 << idx);
      seg_d = {~disp_dp[idx], decode(nib)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= 8'hFF;
      seg_q <= 8'hFF;
      fs_q  <= 1'b0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      fs_q  <= frame_end;
    end
  end

  assign bus.seg_an      = an_q;
  assign bus.seg_out     = seg_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver
module tb_seg7_scan_driver;
  localparam int DIGITS = 8;
  localparam int SCAN_DIV = 4;
  localparam int BLANK_CYCLES = 1;
  localparam int FRAME = DIGITS * SCAN_DIV;

  logic clk;
  logic rst;
  seg7_scan_driver_if bus ();

  seg7_scan_driver #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
    logic       fs;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: time since reset, shown frame, staged frame.
  int          t;
  logic [31:0] m_data, s_data;
  logic [7:0]  m_dp, m_en, s_dp, s_en;
  bit          m_pend;

  always @(posedge clk) begin
    exp_t e;
    int c, i;
    bit bnd;
    logic [7:0] onehot;
    logic [3:0] nib;
    if (rst) begin
      e = '{8'hFF, 8'hFF, 1'b0};
      t = 0; m_pend = 0;
      m_data = '0; m_dp = '0; m_en = '0;
      s_data = '0; s_dp = '0; s_en = '0;
    end else begin
      c = t % SCAN_DIV;
      i = (t / SCAN_DIV) % DIGITS;
      bnd = (c == SCAN_DIV - 1) && (i == DIGITS - 1);
      e = '{8'hFF, 8'hFF, bnd};
      if (c >= BLANK_CYCLES && m_en[i]) begin
        onehot = 8'd1 << i;
        nib = m_data[4*i +: 4];
        e.an = ~onehot;
        e.seg = {~m_dp[i], seg_tbl[nib]};
      end
      if (bus.load) begin
        s_data = bus.data_in; s_dp = bus.dp_in; s_en = bus.en_in;
        m_pend = 1;
      end
      if (bnd && m_pend) begin
        m_data = s_data; m_dp = s_dp; m_en = s_en;
        m_pend = 0;
      end
      t++;
    end
    q.push_back(e);
  end

  // Monitor: pop one expectation per presented output cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_checks++;
      if (bus.seg_an !== e.an || bus.seg_out !== e.seg || bus.frame_start !== e.fs) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: got an=%h seg=%h fs=%b, expected an=%h seg=%h fs=%b",
                 $time, bus.seg_an, bus.seg_out, bus.frame_start, e.an, e.seg, e.fs);
      end
    end
  end

  task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
    bus.load = 1'b1; bus.data_in = d; bus.dp_in = dp; bus.en_in = en;
    @(negedge clk);
    bus.load = 1'b0;
    bus.data_in = $urandom; bus.dp_in = 8'($urandom); bus.en_in = 8'($urandom);
  endtask

  task automatic wait_phase(input int p);
    for (int k = 0; k <= FRAME + 2; k++) begin
      if (t % FRAME == p) return;
      @(negedge clk);
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_phase: phase %0d not reached, t=%0d", p, t);
  endtask

  initial begin
    rst = 1'b1;
    bus.load = 1'b0; bus.data_in = '0; bus.dp_in = '0; bus.en_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_load(32'h76543210, 8'h01, 8'hFF);
    repeat (70) @(negedge clk);

    wait_phase(12);
    do_load(32'hFFFFFFFF, 8'h00, 8'hFF);
    repeat (40) @(negedge clk);

    wait_phase(4);
    do_load(32'h11111111, 8'h00, 8'hFF);
    wait_phase(20);
    do_load(32'h22222222, 8'h00, 8'hFF);
    repeat (40) @(negedge clk);

    wait_phase(FRAME - 1);
    do_load(32'hAAAAAAAA, 8'h00, 8'hFF);
    repeat (40) @(negedge clk);

    do_load(32'h89ABCDEF, 8'h04, 8'b0000_0101);
    repeat (70) @(negedge clk);

    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(0, 40)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) wait_phase(FRAME - 1);
      do_load($urandom, 8'($urandom), 8'($urandom));
    end
    repeat (40) @(negedge clk);

    wait_phase(2);
    do_load(32'h01234567, 8'hFF, 8'hFF);
    wait_phase(22);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (70) @(negedge clk);

    do_load(32'hFEDCBA98, 8'h80, 8'hFF);
    repeat (70) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
